// File: rtl/mux_ser_pkg.sv
// rtl/mux_ser_pkg.sv - shared types and constants for the mux serializer control slice
// Contents: state_t (fixed 2-bit encoding), DEFAULT_SEL_W, first_sel/last_sel helpers.
// Optional feature macro used by the slice: MUX_SER_PARITY_EN (ST_PARITY is only reached with it).
package mux_ser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int DEFAULT_SEL_W = 3;

    // Channel visited first in a frame for the given scan direction.
    function automatic int first_sel(input int sel_w, input bit msb_first);
        return msb_first ? ((1 << sel_w) - 1) : 0;
    endfunction

    // Channel visited last; reaching it ends the data phase.
    function automatic int last_sel(input int sel_w, input bit msb_first);
        return msb_first ? 0 : ((1 << sel_w) - 1);
    endfunction

endpackage

// File: rtl/mux_serializer_ctrl_if.sv
// rtl/mux_serializer_ctrl_if.sv - handshake, mux-side and serial-side signals of the serializer
// Modports:
//   slave  - the serializer: takes start/din/y_in, drives ready/a_out/sel/ser_out/ser_valid/done
//   master - the upstream producer/consumer: drives start/din, observes everything else
//   mux    - the mux_8to1 hookup: reads a_out/sel, drives y_in
interface mux_serializer_ctrl_if import mux_ser_pkg::*; #(
    parameter int SEL_W = DEFAULT_SEL_W
);
    localparam int N = 1 << SEL_W;

    logic             start;
    logic [N-1:0]     din;
    logic             ready;
    logic [N-1:0]     a_out;
    logic [SEL_W-1:0] sel;
    logic             y_in;
    logic             ser_out;
    logic             ser_valid;
    logic             done;

    modport slave (
        input  start, din, y_in,
        output ready, a_out, sel, ser_out, ser_valid, done
    );

    modport master (
        output start, din,
        input  ready, a_out, sel, y_in, ser_out, ser_valid, done
    );

    modport mux (
        input  a_out, sel,
        output y_in
    );

endinterface

// File: rtl/mux_8to1.sv
// rtl/mux_8to1.sv - combinational 8:1 bit multiplexer fed by the serializer
// Ports: a[7:0] data inputs, sel[2:0] channel select, y = a[sel].
module mux_8to1 (
    input  logic [7:0] a,
    input  logic [2:0] sel,
    output logic       y
);

    assign y = a[sel];

endmodule

// File: rtl/mux_sel_counter.sv
// rtl/mux_sel_counter.sv - up/down channel-select counter with load, enable and terminal flag
// Ports: clk, rst_n (sync, active low), load (jump to first channel), en (step one channel),
//        cnt[SEL_W-1:0] current channel, tc (cnt is the last channel of the scan).
module mux_sel_counter import mux_ser_pkg::*; #(
    parameter int SEL_W = DEFAULT_SEL_W,
    parameter bit DOWN  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    output logic [SEL_W-1:0] cnt,
    output logic             tc
);

    localparam logic [SEL_W-1:0] FIRST = SEL_W'(first_sel(SEL_W, DOWN));
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(last_sel(SEL_W, DOWN));
    localparam logic [SEL_W-1:0] ONE   = SEL_W'(1);

    // Terminal value is compared explicitly so the counter never wraps.
    assign tc = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= FIRST;
        end else if (en && !tc) begin
            cnt <= DOWN ? (cnt - ONE) : (cnt + ONE);
        end
    end

endmodule

// File: rtl/mux_serializer_ctrl.sv
// rtl/mux_serializer_ctrl.sv - parallel-to-serial control stage driving an external mux_8to1
// Ports: clk, rst_n (sync, active low), bus (mux_serializer_ctrl_if.slave):
//   start/din  - frame request and word, taken while ready=1
//   ready      - high in IDLE
//   a_out/sel  - held word and channel select to the mux; y_in is the mux output
//   ser_out    - registered serial bit, ser_valid marks frame bits
//   done       - one-cycle pulse after the last frame bit
// Macro MUX_SER_PARITY_EN appends an even-parity bit to every frame.
module mux_serializer_ctrl import mux_ser_pkg::*; #(
    parameter int SEL_W     = DEFAULT_SEL_W,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux_serializer_ctrl_if.slave  bus
);

    localparam int N = 1 << SEL_W;

    state_t           state;
    logic [N-1:0]     a_q;
    logic             ser_q;
    logic             valid_q;
    logic             done_q;
    logic [SEL_W-1:0] sel_q;
    logic             cnt_tc;
    logic             accept;
    logic             cnt_en;

    // A frame is taken in IDLE, or on the closing DONE edge when start is
    // still held, which keeps back-to-back frames at N+2 cycles apart.
    assign accept = bus.start &&
                    ((state == ST_IDLE) || ((state == ST_DONE) && done_q));
    assign cnt_en = (state == ST_SHIFT);

    mux_sel_counter #(
        .SEL_W (SEL_W),
        .DOWN  (MSB_FIRST)
    ) u_sel_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .en    (cnt_en),
        .cnt   (sel_q),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            a_q     <= '0;
            ser_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                    if (bus.start) begin
                        a_q   <= bus.din;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // y_in reflects the channel selected during this cycle.
                    ser_q   <= bus.y_in;
                    valid_q <= 1'b1;
                    if (cnt_tc) begin
`ifdef MUX_SER_PARITY_EN
                        state <= ST_PARITY;
`else
                        state <= ST_DONE;
`endif
                    end
                end
`ifdef MUX_SER_PARITY_EN
                ST_PARITY: begin
                    ser_q   <= ^a_q;
                    valid_q <= 1'b1;
                    state   <= ST_DONE;
                end
`endif
                ST_DONE: begin
                    // Two cycles: the first edge raises done, the second
                    // clears it and either returns to IDLE or chains a frame.
                    valid_q <= 1'b0;
                    if (!done_q) begin
                        done_q <= 1'b1;
                    end else begin
                        done_q <= 1'b0;
                        if (bus.start) begin
                            a_q   <= bus.din;
                            state <= ST_SHIFT;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = (state == ST_IDLE);
    assign bus.a_out     = a_q;
    assign bus.sel       = sel_q;
    assign bus.ser_out   = ser_q;
    assign bus.ser_valid = valid_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_mux_serializer_ctrl.sv
// tb/tb_mux_serializer_ctrl.sv - scoreboard bench for mux_serializer_ctrl in both scan directions
module tb_mux_serializer_ctrl;
    import mux_ser_pkg::*;

    localparam int SEL_W = 3;
    localparam int N     = 8;
`ifdef MUX_SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int P = N + 2 + PAR;

    typedef struct {
        logic b;
        int   ch;
        int   t;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] din;

    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    int   ps0 = 0;
    int   ps1 = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   dq0[$];
    int   dq1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mux_serializer_ctrl_if #(.SEL_W(SEL_W)) b0 ();
    mux_serializer_ctrl_if #(.SEL_W(SEL_W)) b1 ();

    assign b0.start = start;
    assign b0.din   = din;
    assign b1.start = start;
    assign b1.din   = din;

    mux_8to1 m0 (.a(b0.a_out), .sel(b0.sel), .y(b0.y_in));
    mux_8to1 m1 (.a(b1.a_out), .sel(b1.sel), .y(b1.y_in));

    mux_serializer_ctrl #(.SEL_W(SEL_W), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0.slave)
    );
    mux_serializer_ctrl #(.SEL_W(SEL_W), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic mon(input int w, input logic v, input logic so, input int ps, input logic dn);
        exp_t e;
        int   t;
        bit   empty;
        if (v === 1'b1) begin
            empty = (w == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                chk($sformatf("dut%0d_extra_bit", w), cyc, -1);
            end else begin
                if (w == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("dut%0d_bit_t%0d", w, e.t), int'(so), int'(e.b));
                chk($sformatf("dut%0d_sel_t%0d", w, e.t), ps, e.ch);
                chk($sformatf("dut%0d_bit_time", w), cyc, e.t);
            end
        end
        if (dn === 1'b1) begin
            empty = (w == 0) ? (dq0.size() == 0) : (dq1.size() == 0);
            if (empty) begin
                chk($sformatf("dut%0d_extra_done", w), cyc, -1);
            end else begin
                if (w == 0) t = dq0.pop_front();
                else        t = dq1.pop_front();
                chk($sformatf("dut%0d_done_time", w), cyc, t);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, b0.ser_valid, b0.ser_out, ps0, b0.done);
            mon(1, b1.ser_valid, b1.ser_out, ps1, b1.done);
        end
        ps0 <= int'(b0.sel);
        ps1 <= int'(b1.sel);
    end

    // Expected stream of one frame accepted at edge c0: nb bits, optional done.
    task automatic push_frame(input int c0, input logic [7:0] d, input int nb, input bit with_done);
        exp_t e;
        for (int j = 0; j < nb; j++) begin
            e.t = c0 + 1 + j;
            if (j < N) begin
                e.ch = j;         e.b = d[j];         q0.push_back(e);
                e.ch = N - 1 - j; e.b = d[N - 1 - j]; q1.push_back(e);
            end else begin
                e.b = ^d;
                e.ch = N - 1; q0.push_back(e);
                e.ch = 0;     q1.push_back(e);
            end
        end
        if (with_done) begin
            dq0.push_back(c0 + N + 1 + PAR);
            dq1.push_back(c0 + N + 1 + PAR);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] d, output int c0);
        start = 1'b1;
        din   = d;
        c0    = cyc + 1;
        push_frame(c0, d, N + PAR, 1'b1);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_ready(input int c0, input string name);
        int n = 0;
        while (b0.ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk(name, cyc - c0, N + 2 + PAR);
        chk({name, "_msb"}, int'(b1.ready), 1);
    endtask

    task automatic hold_check(input logic [7:0] d, input string name);
        logic e0, e1;
        e0 = (PAR == 1) ? ^d : d[N - 1];
        e1 = (PAR == 1) ? ^d : d[0];
        chk({name, "_hold0"}, int'(b0.ser_out), int'(e0));
        chk({name, "_hold1"}, int'(b1.ser_out), int'(e1));
        chk({name, "_idle_valid0"}, int'(b0.ser_valid), 0);
    endtask

    task automatic reset_checks(input string p);
        chk({p, "_ready0"}, int'(b0.ready), 1);
        chk({p, "_ready1"}, int'(b1.ready), 1);
        chk({p, "_a0"}, int'(b0.a_out), 0);
        chk({p, "_a1"}, int'(b1.a_out), 0);
        chk({p, "_sel0"}, int'(b0.sel), 0);
        chk({p, "_sel1"}, int'(b1.sel), 0);
        chk({p, "_ser0"}, int'(b0.ser_out), 0);
        chk({p, "_ser1"}, int'(b1.ser_out), 0);
        chk({p, "_valid0"}, int'(b0.ser_valid), 0);
        chk({p, "_valid1"}, int'(b1.ser_valid), 0);
        chk({p, "_done0"}, int'(b0.done), 0);
        chk({p, "_done1"}, int'(b1.done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        din   = 8'h00;
        repeat (3) tick();
        reset_checks("por");
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick();

        // 8'hA5: LSB scan 1,0,1,0,0,1,0,1; MSB scan bits 7..0 = 1,0,1,0,0,1,0,1
        launch(8'hA5, c0);
        wait_ready(c0, "a5_ready");
        hold_check(8'hA5, "a5");
        tick();

        // 8'hF0 accepted; 8'h0F offered mid-frame must be ignored
        launch(8'hF0, c0);
        tick();
        tick();
        start = 1'b1;
        din   = 8'h0F;
        tick();
        start = 1'b0;
        din   = 8'h00;
        n = 0;
        while (b0.ready !== 1'b1 && n < 40) begin
            chk("f0_aout0", int'(b0.a_out), 8'hF0);
            chk("f0_aout1", int'(b1.a_out), 8'hF0);
            tick();
            n++;
        end
        chk("f0_ready", cyc - c0, N + 2 + PAR);
        hold_check(8'hF0, "f0");
        tick();

        // Reset during the frame: three bits escape, no done afterwards
        start = 1'b1;
        din   = 8'h96;
        c0    = cyc + 1;
        push_frame(c0, 8'h96, 3, 1'b0);
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        reset_checks("midrst");
        rst_n = 1'b1;
        tick();
        launch(8'h3C, c0);
        wait_ready(c0, "3c_ready");
        hold_check(8'h3C, "3c");
        tick();

        // start held with 8'hFF: three chained frames P cycles apart
        start = 1'b1;
        din   = 8'hFF;
        c0    = cyc + 1;
        for (int k = 0; k < 3; k++) push_frame(c0 + k * P, 8'hFF, N + PAR, 1'b1);
        n = 0;
        while (cyc < c0 + 2 * P && n < 100) begin
            tick();
            n++;
        end
        start = 1'b0;
        wait_ready(c0 + 2 * P, "ff_ready");
        tick();

        // Parity-focused words (parity 1 and 0)
        launch(8'h07, c0);
        wait_ready(c0, "07_ready");
        hold_check(8'h07, "07");
        launch(8'h03, c0);
        wait_ready(c0, "03_ready");
        hold_check(8'h03, "03");

        repeat (4) tick();
        chk("drain_bits0", q0.size(), 0);
        chk("drain_bits1", q1.size(), 0);
        chk("drain_done0", dq0.size(), 0);
        chk("drain_done1", dq1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
